// File: rtl/entrada_jogada_pkg.sv
// rtl/entrada_jogada_pkg.sv - shared state codes, defaults and one-hot encoder for move entry
package entrada_jogada_pkg;

    localparam int DEBOUNCE_PADRAO = 50000;
    localparam int TIMEOUT_PADRAO  = 250000000;

    typedef enum logic [3:0] {
        VAZIO     = 4'd0,
        SO_LINHA  = 4'd1,
        SO_COLUNA = 4'd2,
        COMPLETO  = 4'd3,
        EMITE     = 4'd4
    } estado_t;

    typedef struct packed {
        logic [2:0] indice;
        logic       algum;
        logic       multiplo;
    } codif_t;

    // Encodes an 8-bit event vector; multiplo flags two or more simultaneous bits
    function automatic codif_t codifica_onehot(input logic [7:0] v);
        codif_t     r;
        logic [3:0] soma;
        r.indice = 3'd0;
        soma     = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                r.indice = 3'(i);
                soma     = soma + 4'd1;
            end
        end
        r.algum    = (soma != 4'd0);
        r.multiplo = (soma > 4'd1);
        return r;
    endfunction

endpackage

// File: rtl/entrada_jogada_debounce_botao.sv
// rtl/entrada_jogada_debounce_botao.sv - 2-FF synchronizer, debouncer and press-event generator
module debounce_botao
    import entrada_jogada_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
    input  logic clock,
    input  logic reset,
    input  logic bruto,
    output logic evento
);

    localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;

    logic          sinc1;
    logic          sinc2;
    logic          estavel;
    logic [CW-1:0] contagem;

    // Stable level follows the synchronized input only after an unbroken run of differing cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc1    <= 1'b0;
            sinc2    <= 1'b0;
            estavel  <= 1'b0;
            contagem <= '0;
            evento   <= 1'b0;
        end else begin
            sinc1  <= bruto;
            sinc2  <= sinc1;
            evento <= 1'b0;
            if (sinc2 != estavel) begin
                if (contagem == CW'(DEBOUNCE_CICLOS - 1)) begin
                    estavel  <= sinc2;
                    contagem <= '0;
                    evento   <= sinc2;
                end else begin
                    contagem <= contagem + CW'(1);
                end
            end else begin
                contagem <= '0;
            end
        end
    end

endmodule

// File: rtl/entrada_jogada.sv
// rtl/entrada_jogada.sv - move-entry front end; optional idle timeout via ENTRADA_TIMEOUT_EN
module entrada_jogada
    import entrada_jogada_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
    parameter int TIMEOUT_CICLOS  = TIMEOUT_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] botoesLinha,
    input  logic [7:0] botoesColuna,
    input  logic       confirmar,
    input  logic       cancelar,
    output logic [2:0] jogadaFileira,
    output logic [2:0] jogadaColuna,
    output logic       temJogada,
    output logic       erroEntrada,
    output logic [3:0] db_estado
);

    logic [7:0] ev_linha;
    logic [7:0] ev_coluna;
    logic       ev_confirmar;
    logic       ev_cancelar;

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_botoes
            debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_linha (
                .clock  (clock),
                .reset  (reset),
                .bruto  (botoesLinha[g]),
                .evento (ev_linha[g])
            );
            debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_coluna (
                .clock  (clock),
                .reset  (reset),
                .bruto  (botoesColuna[g]),
                .evento (ev_coluna[g])
            );
        end
    endgenerate

    debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_confirmar (
        .clock  (clock),
        .reset  (reset),
        .bruto  (confirmar),
        .evento (ev_confirmar)
    );

    debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_cancelar (
        .clock  (clock),
        .reset  (reset),
        .bruto  (cancelar),
        .evento (ev_cancelar)
    );

    codif_t  cod_linha;
    codif_t  cod_coluna;
    logic    valida_linha;
    logic    valida_coluna;
    estado_t estado;
    estado_t proximo;
    logic    carga_linha;
    logic    carga_coluna;
    logic    limpa;
    logic    erro;
    logic    expira;

    assign cod_linha     = codifica_onehot(ev_linha);
    assign cod_coluna    = codifica_onehot(ev_coluna);
    assign valida_linha  = cod_linha.algum & ~cod_linha.multiplo;
    assign valida_coluna = cod_coluna.algum & ~cod_coluna.multiplo;

`ifdef ENTRADA_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

    logic [TW-1:0] ocioso;
    logic          em_selecao;

    assign em_selecao = (estado == SO_LINHA) || (estado == SO_COLUNA) || (estado == COMPLETO);
    assign expira     = em_selecao && (ocioso == TW'(TIMEOUT_CICLOS - 1));

    // Idle counter runs only while a partial or complete selection is pending
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ocioso <= '0;
        end else if (!em_selecao || expira || carga_linha || carga_coluna) begin
            ocioso <= '0;
        end else begin
            ocioso <= ocioso + TW'(1);
        end
    end
`else
    assign expira = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= VAZIO;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state and load decisions; cancel (or expiry) outranks everything except EMITE
    always_comb begin
        proximo      = estado;
        carga_linha  = 1'b0;
        carga_coluna = 1'b0;
        limpa        = 1'b0;
        erro         = 1'b0;
        case (estado)
            EMITE: begin
                proximo = VAZIO;
            end
            VAZIO, SO_LINHA, SO_COLUNA, COMPLETO: begin
                if (ev_cancelar || expira) begin
                    proximo = VAZIO;
                    limpa   = 1'b1;
                end else begin
                    erro         = cod_linha.multiplo | cod_coluna.multiplo;
                    carga_linha  = valida_linha;
                    carga_coluna = valida_coluna;
                    case (estado)
                        VAZIO: begin
                            if (valida_linha && valida_coluna) begin
                                proximo = COMPLETO;
                            end else if (valida_linha) begin
                                proximo = SO_LINHA;
                            end else if (valida_coluna) begin
                                proximo = SO_COLUNA;
                            end
                        end
                        SO_LINHA: begin
                            if (valida_coluna) begin
                                proximo = COMPLETO;
                            end
                        end
                        SO_COLUNA: begin
                            if (valida_linha) begin
                                proximo = COMPLETO;
                            end
                        end
                        default: begin
                            if (ev_confirmar) begin
                                proximo = EMITE;
                            end
                        end
                    endcase
                end
            end
            default: begin
                proximo = VAZIO;
            end
        endcase
    end

    // Coordinate registers hold until the next accepted press or a clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            jogadaFileira <= 3'd0;
            jogadaColuna  <= 3'd0;
        end else if (limpa) begin
            jogadaFileira <= 3'd0;
            jogadaColuna  <= 3'd0;
        end else begin
            if (carga_linha) begin
                jogadaFileira <= cod_linha.indice;
            end
            if (carga_coluna) begin
                jogadaColuna <= cod_coluna.indice;
            end
        end
    end

    assign temJogada   = (estado == EMITE);
    assign erroEntrada = erro;
    assign db_estado   = estado;

endmodule

// File: tb/tb_entrada_jogada.sv
// tb/tb_entrada_jogada.sv - directed self-checking bench for entrada_jogada
module tb_entrada_jogada;

    logic       clock;
    logic       reset;
    logic [7:0] botoesLinha;
    logic [7:0] botoesColuna;
    logic       confirmar;
    logic       cancelar;
    logic [2:0] jogadaFileira;
    logic [2:0] jogadaColuna;
    logic       temJogada;
    logic       erroEntrada;
    logic [3:0] db_estado;

    int checks;
    int passes;
    int n_tem;
    int n_erro;
    logic [3:0] ultimo;
    logic [3:0] seq[$];

    entrada_jogada #(.DEBOUNCE_CICLOS(4), .TIMEOUT_CICLOS(64)) dut (
        .clock         (clock),
        .reset         (reset),
        .botoesLinha   (botoesLinha),
        .botoesColuna  (botoesColuna),
        .confirmar     (confirmar),
        .cancelar      (cancelar),
        .jogadaFileira (jogadaFileira),
        .jogadaColuna  (jogadaColuna),
        .temJogada     (temJogada),
        .erroEntrada   (erroEntrada),
        .db_estado     (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            if (temJogada) n_tem++;
            if (erroEntrada) n_erro++;
            if (db_estado != ultimo) seq.push_back(db_estado);
        end
        ultimo = db_estado;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic limpa_log();
        n_tem  = 0;
        n_erro = 0;
        seq.delete();
    endtask

    task automatic aperta(input logic [7:0] l, input logic [7:0] c, input logic conf, input logic canc);
        botoesLinha  = l;
        botoesColuna = c;
        confirmar    = conf;
        cancelar     = canc;
        repeat (10) tick();
        botoesLinha  = 8'h00;
        botoesColuna = 8'h00;
        confirmar    = 1'b0;
        cancelar     = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        botoesLinha = 8'h00; botoesColuna = 8'h00; confirmar = 1'b0; cancelar = 1'b0;
        repeat (3) tick();
        checks++; if ({jogadaFileira, jogadaColuna, temJogada, erroEntrada, db_estado} !== 12'd0)
            $display("FAIL reset_outputs got %h want 0", {jogadaFileira, jogadaColuna, temJogada, erroEntrada, db_estado}); else passes++;
        reset = 1'b0;
        tick();
        checks++; if (db_estado !== 4'd0) $display("FAIL reset_state got %0d want 0", db_estado); else passes++;
    endtask

    task automatic test_jogada_basica();
        limpa_log();
        aperta(8'b0010_0000, 8'h00, 1'b0, 1'b0);
        aperta(8'h00, 8'b0000_0100, 1'b0, 1'b0);
        aperta(8'h00, 8'h00, 1'b1, 1'b0);
        checks++; if (n_tem !== 1) $display("FAIL basic_tem_cycles got %0d want 1", n_tem); else passes++;
        checks++; if (jogadaFileira !== 3'd5) $display("FAIL basic_fileira got %0d want 5", jogadaFileira); else passes++;
        checks++; if (jogadaColuna !== 3'd2) $display("FAIL basic_coluna got %0d want 2", jogadaColuna); else passes++;
        checks++; if (seq.size() !== 4) $display("FAIL basic_seq_len got %0d want 4", seq.size());
        else if (seq[0] !== 4'd1 || seq[1] !== 4'd3 || seq[2] !== 4'd4 || seq[3] !== 4'd0)
            $display("FAIL basic_seq got %0d,%0d,%0d,%0d want 1,3,4,0", seq[0], seq[1], seq[2], seq[3]);
        else passes++;
    endtask

    task automatic test_debounce();
        int lat;
        limpa_log();
        for (int i = 0; i < 10; i++) begin
            botoesLinha[3] = ~botoesLinha[3];
            repeat (2) tick();
        end
        botoesLinha = 8'h00;
        checks++; if (seq.size() !== 0 || db_estado !== 4'd0)
            $display("FAIL bounce_ignored got state %0d changes %0d want 0 0", db_estado, seq.size()); else passes++;
        botoesLinha[3] = 1'b1;
        lat = 0;
        while (dut.ev_linha[3] !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 6) $display("FAIL debounce_latency got %0d want 6", lat); else passes++;
        tick();
        checks++; if (db_estado !== 4'd1) $display("FAIL debounce_state got %0d want 1", db_estado); else passes++;
        repeat (8) tick();
        botoesLinha = 8'h00;
        repeat (10) tick();
    endtask

    task automatic test_back_to_back();
        limpa_log();
        aperta(8'h00, 8'b0000_0010, 1'b0, 1'b0);
        aperta(8'h00, 8'h00, 1'b1, 1'b0);
        checks++; if (n_tem !== 1 || jogadaFileira !== 3'd3 || jogadaColuna !== 3'd1)
            $display("FAIL b2b_move got tem %0d r%0d c%0d want 1 r3 c1", n_tem, jogadaFileira, jogadaColuna); else passes++;
    endtask

    task automatic test_ambiguo();
        limpa_log();
        aperta(8'b0100_0010, 8'h00, 1'b0, 1'b0);
        checks++; if (n_erro !== 1) $display("FAIL amb_erro got %0d want 1", n_erro); else passes++;
        checks++; if (db_estado !== 4'd0 || seq.size() !== 0)
            $display("FAIL amb_state got %0d changes %0d want 0 0", db_estado, seq.size()); else passes++;
        checks++; if (jogadaFileira !== 3'd3) $display("FAIL amb_fileira got %0d want 3", jogadaFileira); else passes++;
    endtask

    task automatic test_cancel();
        limpa_log();
        aperta(8'b0001_0000, 8'h00, 1'b0, 1'b0);
        aperta(8'h00, 8'b1000_0000, 1'b0, 1'b0);
        checks++; if (db_estado !== 4'd3 || jogadaFileira !== 3'd4 || jogadaColuna !== 3'd7)
            $display("FAIL cancel_pre got s%0d r%0d c%0d want s3 r4 c7", db_estado, jogadaFileira, jogadaColuna); else passes++;
        aperta(8'h00, 8'h00, 1'b0, 1'b1);
        checks++; if (db_estado !== 4'd0 || jogadaFileira !== 3'd0 || jogadaColuna !== 3'd0)
            $display("FAIL cancel_post got s%0d r%0d c%0d want s0 r0 c0", db_estado, jogadaFileira, jogadaColuna); else passes++;
        aperta(8'h00, 8'h00, 1'b1, 1'b0);
        checks++; if (n_tem !== 0) $display("FAIL cancel_confirm got %0d want 0", n_tem); else passes++;
    endtask

    task automatic test_confirma_cedo();
        limpa_log();
        aperta(8'b0000_0100, 8'h00, 1'b0, 1'b0);
        aperta(8'h00, 8'h00, 1'b1, 1'b0);
        checks++; if (db_estado !== 4'd1 || n_tem !== 0)
            $display("FAIL early_confirm got s%0d tem %0d want s1 0", db_estado, n_tem); else passes++;
        aperta(8'h00, 8'b0000_0001, 1'b0, 1'b0);
        aperta(8'h00, 8'h00, 1'b1, 1'b0);
        checks++; if (n_tem !== 1 || jogadaFileira !== 3'd2 || jogadaColuna !== 3'd0)
            $display("FAIL early_move got tem %0d r%0d c%0d want 1 r2 c0", n_tem, jogadaFileira, jogadaColuna); else passes++;
    endtask

    task automatic test_reset_meio();
        aperta(8'b0100_0000, 8'h00, 1'b0, 1'b0);
        checks++; if (db_estado !== 4'd1 || jogadaFileira !== 3'd6)
            $display("FAIL midreset_pre got s%0d r%0d want s1 r6", db_estado, jogadaFileira); else passes++;
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({jogadaFileira, jogadaColuna, temJogada, erroEntrada, db_estado} !== 12'd0)
            $display("FAIL midreset_async got %h want 0", {jogadaFileira, jogadaColuna, temJogada, erroEntrada, db_estado}); else passes++;
        tick();
        reset = 1'b0;
        tick();
    endtask

`ifdef ENTRADA_TIMEOUT_EN
    task automatic test_timeout();
        aperta(8'b0000_0010, 8'h00, 1'b0, 1'b0);
        checks++; if (db_estado !== 4'd1) $display("FAIL timeout_pre got %0d want 1", db_estado); else passes++;
        repeat (64) tick();
        checks++; if (db_estado !== 4'd0 || jogadaFileira !== 3'd0)
            $display("FAIL timeout_post got s%0d r%0d want s0 r0", db_estado, jogadaFileira); else passes++;
    endtask
`endif

    initial begin
        checks = 0;
        passes = 0;
        n_tem  = 0;
        n_erro = 0;
        test_reset();
        test_jogada_basica();
        test_debounce();
        test_back_to_back();
        test_ambiguo();
        test_cancel();
        test_confirma_cedo();
        test_reset_meio();
`ifdef ENTRADA_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
